// File: rtl/alu_cc_pkg.sv
// rtl/alu_cc_pkg.sv - shared width, opcode type and control-priority decode for alu_cc.
package alu_cc_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {OP_ADD, OP_ADC, OP_SUB, OP_SBB} op_t;

  // SBB wins over SUB, which wins over ADC; nothing asserted means plain ADD.
  function automatic op_t decode_op(input logic adc, input logic sub, input logic sbb);
    if (sbb)
      return OP_SBB;
    else if (sub)
      return OP_SUB;
    else if (adc)
      return OP_ADC;
    else
      return OP_ADD;
  endfunction

endpackage

// File: rtl/alu_cc_if.sv
// rtl/alu_cc_if.sv - operand/control and result/flag bundle between the datapath and alu_cc.
interface alu_cc_if;
  import alu_cc_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Pre_C;
  logic             ADC;
  logic             SUB;
  logic             SBB;
  logic [WIDTH-1:0] Y;
  logic             Z;
  logic             V;
  logic             C;
  logic             N;

  modport master (
    output A, B, Pre_C, ADC, SUB, SBB,
    input  Y, Z, V, C, N
  );

  modport slave (
    input  A, B, Pre_C, ADC, SUB, SBB,
    output Y, Z, V, C, N
  );

endinterface

// File: rtl/alu_cc_adder.sv
// rtl/alu_cc_adder.sv - W-bit adder with carry in/out; ALU_CC_CLA_EN selects 4-bit lookahead
// groups with rippled group carries, otherwise a plain ripple chain.
module alu_cc_adder
  import alu_cc_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

`ifdef ALU_CC_CLA_EN
  // Returns {group carry out, 4-bit sum}; all carries inside the group are flattened.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    logic       c;
    logic [4:0] grp;
    c   = cin;
    grp = '0;
    sum = '0;
    for (int k = 0; k < W / 4; k++) begin
      grp            = cla4(a[k*4 +: 4], b[k*4 +: 4], c);
      sum[k*4 +: 4]  = grp[3:0];
      c              = grp[4];
    end
    cout = c;
  end
`else
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
`endif

endmodule

// File: rtl/alu_cc.sv
// rtl/alu_cc.sv - registered 16-bit ADD/ADC/SUB/SBB ALU with Z/V/C/N flags;
// adder structure chosen by ALU_CC_CLA_EN inside alu_cc_adder.
module alu_cc
  import alu_cc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  alu_cc_if.slave bus
);

  op_t              op;
  logic             is_sub;
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] r;
  logic             co;
  logic             c_next;
  logic             v_next;

  always_comb begin
    op     = decode_op(bus.ADC, bus.SUB, bus.SBB);
    is_sub = (op == OP_SUB) || (op == OP_SBB);
    bx     = is_sub ? ~bus.B : bus.B;
    unique case (op)
      OP_ADD:  cin = 1'b0;
      OP_ADC:  cin = bus.Pre_C;
      OP_SUB:  cin = 1'b1;
      OP_SBB:  cin = ~bus.Pre_C;
      default: cin = 1'b0;
    endcase
  end

  alu_cc_adder #(.W(WIDTH)) u_adder (
    .a    (bus.A),
    .b    (bx),
    .cin  (cin),
    .sum  (r),
    .cout (co)
  );

  // Subtracts report borrow, which is the inverted adder carry.
  always_comb begin
    c_next = is_sub ? ~co : co;
    v_next = (bus.A[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != bus.A[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Y <= '0;
      bus.Z <= 1'b0;
      bus.V <= 1'b0;
      bus.C <= 1'b0;
      bus.N <= 1'b0;
    end else begin
      bus.Y <= r;
      bus.Z <= (r == '0);
      bus.V <= v_next;
      bus.C <= c_next;
      bus.N <= r[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_cc.sv
// tb/tb_alu_cc.sv - scoreboard bench for alu_cc with directed, hand-computed vectors.
module tb_alu_cc;

  logic clk;
  logic rst_n;

  alu_cc_if bus_if ();

  alu_cc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [15:0] y;
    logic [3:0]  zvcn;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string name, input logic [15:0] y, input logic [3:0] zvcn);
    logic [19:0] act;
    logic [19:0] req;
    act = {bus_if.Y, bus_if.Z, bus_if.V, bus_if.C, bus_if.N};
    req = {y, zvcn};
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got Y=%h ZVCN=%b, expected Y=%h ZVCN=%b",
               name, act[19:4], act[3:0], req[19:4], req[3:0]);
    end
  endtask

  task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic pc, input logic adc, input logic sub, input logic sbb,
                       input logic [15:0] ey, input logic [3:0] ezvcn);
    exp_t e;
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
    bus_if.Pre_C = pc;
    bus_if.ADC   = adc;
    bus_if.SUB   = sub;
    bus_if.SBB   = sbb;
    e.y    = ey;
    e.zvcn = ezvcn;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every edge presents a registered result; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_out(e.name, e.y, e.zvcn);
      end
    end
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus_if.A     = '0;
    bus_if.B     = '0;
    bus_if.Pre_C = 1'b0;
    bus_if.ADC   = 1'b0;
    bus_if.SUB   = 1'b0;
    bus_if.SBB   = 1'b0;
    #1;
    check_out("reset_state", 16'h0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_held_over_edge", 16'h0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    //                                   A        B        pc adc sub sbb  Y        ZVCN
    apply("add_zero",               16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'b1000);
    apply("add_basic",              16'h1234, 16'h2345, 0, 0, 0, 0, 16'h3579, 4'b0000);
    apply("adc_pc0",                16'h1234, 16'h2345, 0, 1, 0, 0, 16'h3579, 4'b0000);
    apply("adc_pc1",                16'h1234, 16'h2345, 1, 1, 0, 0, 16'h357A, 4'b0000);
    apply("add_ignores_pc",         16'h1234, 16'h2345, 1, 0, 0, 0, 16'h3579, 4'b0000);
    apply("sub_pc0",                16'h1234, 16'h2345, 0, 0, 1, 0, 16'hEEEF, 4'b0011);
    apply("sub_pc1",                16'h1234, 16'h2345, 1, 0, 1, 0, 16'hEEEF, 4'b0011);
    apply("sbb_pc0",                16'h1234, 16'h2345, 0, 0, 0, 1, 16'hEEEF, 4'b0011);
    apply("sbb_pc1",                16'h1234, 16'h2345, 1, 0, 0, 1, 16'hEEEE, 4'b0011);
    apply("add_signed_ovf",         16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 4'b0101);
    apply("add_carry_wrap",         16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 4'b1010);
    apply("sub_signed_ovf",         16'h8000, 16'h0001, 0, 0, 1, 0, 16'h7FFF, 4'b0100);
    apply("priority_all",           16'h0005, 16'h0003, 1, 1, 1, 1, 16'h0001, 4'b0000);
    apply("priority_sub_over_adc",  16'h0005, 16'h0003, 1, 1, 1, 0, 16'h0002, 4'b0000);
    apply("sbb_zero_borrow",        16'h0000, 16'h0000, 1, 0, 0, 1, 16'hFFFF, 4'b0011);
    apply("adc_wrap",               16'hFFFF, 16'h0000, 1, 1, 0, 0, 16'h0000, 4'b1010);
    apply("sub_equal",              16'h0005, 16'h0005, 0, 0, 1, 0, 16'h0000, 4'b1000);
    apply("adc_ovf_by_cin",         16'h7FFF, 16'h0000, 1, 1, 0, 0, 16'h8000, 4'b0101);
    drain();

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    apply("pre_async_load",         16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 4'b0101);
    drain();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_reset_midcycle", 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    check_out("async_reset_held", 16'h0000, 4'b0000);
    #2;
    rst_n = 1'b1;
    apply("first_after_release",    16'h1234, 16'h2345, 1, 1, 0, 0, 16'h357A, 4'b0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
